dbi_tx_fsm: RTL

DBI_TX_FSM -- requirements
Module: dbi_tx_fsm

---
 rtl/dbi_tx_fsm.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dbi_tx_fsm.sv
// dbi_tx_fsm: DBI Type-B write-only transmitter (panel init, column/row window, pixel stream); DBI_TX_SOFT_RST_EN adds soft-reset + delay.
// Registered bus, 2 cycles/byte; pxl_ready_o only in PIXEL issue slots, bus idles (wrx=1, csx=0) while pxl_valid_i=0.
module dbi_tx_fsm #(
  parameter int DATA_W      = 8,
  parameter int PIXEL_NUM   = 153600,
  parameter int RST_DLY_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbi_tx_start_i,
  input  logic [DATA_W-1:0] addr_soft_rst_i,
  input  logic [DATA_W-1:0] addr_disp_on_i,
  input  logic [DATA_W-1:0] addr_col_i,
  input  logic [DATA_W-1:0] addr_row_i,
  input  logic [DATA_W-1:0] addr_mem_wr_i,
  input  logic [DATA_W-1:0] cmd_s_col_h_i,
  input  logic [DATA_W-1:0] cmd_s_col_l_i,
  input  logic [DATA_W-1:0] cmd_e_col_h_i,
  input  logic [DATA_W-1:0] cmd_e_col_l_i,
  input  logic [DATA_W-1:0] cmd_s_row_h_i,
  input  logic [DATA_W-1:0] cmd_s_row_l_i,
  input  logic [DATA_W-1:0] cmd_e_row_h_i,
  input  logic [DATA_W-1:0] cmd_e_row_l_i,
  input  logic [DATA_W-1:0] pxl_data_i,
  input  logic              pxl_valid_i,
  output logic              pxl_ready_o,
  output logic              dbi_csx_o,
  output logic              dbi_dcx_o,
  output logic              dbi_wrx_o,
  output logic              dbi_rdx_o,
  output logic [DATA_W-1:0] dbi_d_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  typedef enum logic [2:0] {
    IDLE, SRST, SRST_WAIT, DISP_ON, SET_COL, SET_ROW, MEM_WR, PIXEL
  } state_t;

  localparam int PW = $clog2(PIXEL_NUM + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_NUM);

  state_t            state_q, state_d;
  logic              init_done_q, init_done_d;
  logic [2:0]        idx_q, idx_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              csx_q, csx_d;
  logic              dcx_q, dcx_d;
  logic              wrx_q, wrx_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              fdone_q, fdone_d;

  logic              issue;
  logic [DATA_W-1:0] issue_dat;
  logic              issue_dcx;
  logic [DATA_W-1:0] col_byte, row_byte;

`ifdef DBI_TX_SOFT_RST_EN
  localparam int WW = (RST_DLY_CYC > 0) ? $clog2(RST_DLY_CYC + 1) : 1;
  localparam logic [WW-1:0] DLY_LAST = WW'(RST_DLY_CYC);
  logic [WW-1:0] wcnt_q, wcnt_d;
`else
  localparam int unused_dly = RST_DLY_CYC;
  logic unused_srst;
  assign unused_srst = ^addr_soft_rst_i;
`endif

  // Window setup sends the opcode at index 0, then four parameter bytes.
  always_comb begin
    col_byte = addr_col_i;
    row_byte = addr_row_i;
    unique case (idx_q)
      3'd1:    begin col_byte = cmd_s_col_h_i; row_byte = cmd_s_row_h_i; end
      3'd2:    begin col_byte = cmd_s_col_l_i; row_byte = cmd_s_row_l_i; end
      3'd3:    begin col_byte = cmd_e_col_h_i; row_byte = cmd_e_row_h_i; end
      3'd4:    begin col_byte = cmd_e_col_l_i; row_byte = cmd_e_row_l_i; end
      default: begin col_byte = addr_col_i;    row_byte = addr_row_i;    end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    idx_d       = idx_q;
    pcnt_d      = pcnt_q;
    csx_d       = csx_q;
    dcx_d       = dcx_q;
    wrx_d       = 1'b1;
    d_d         = d_q;
    fdone_d     = 1'b0;
    issue       = 1'b0;
    issue_dat   = '0;
    issue_dcx   = 1'b1;
    pxl_ready_o = 1'b0;
`ifdef DBI_TX_SOFT_RST_EN
    wcnt_d      = wcnt_q;
`endif

    // A new byte may only be issued once the previous strobe is back high.
    unique case (state_q)
      IDLE: begin
        csx_d = 1'b1;
        idx_d = '0;
        if (dbi_tx_start_i) begin
`ifdef DBI_TX_SOFT_RST_EN
          state_d = init_done_q ? SET_COL : SRST;
`else
          state_d = init_done_q ? SET_COL : DISP_ON;
`endif
        end
      end
`ifdef DBI_TX_SOFT_RST_EN
      SRST: begin
        if (wrx_q) begin
          issue     = 1'b1;
          issue_dat = addr_soft_rst_i;
          issue_dcx = 1'b0;
          wcnt_d    = '0;
          state_d   = SRST_WAIT;
        end
      end
      SRST_WAIT: begin
        // Deselect only after the soft-reset byte's strobe-high cycle.
        if (wrx_q) csx_d = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == DLY_LAST) state_d = DISP_ON;
      end
`endif
      DISP_ON: begin
        if (wrx_q) begin
          issue       = 1'b1;
          issue_dat   = addr_disp_on_i;
          issue_dcx   = 1'b0;
          init_done_d = 1'b1;
          idx_d       = '0;
          state_d     = SET_COL;
        end
      end
      SET_COL: begin
        if (wrx_q) begin
          issue     = 1'b1;
          issue_dat = col_byte;
          issue_dcx = (idx_q != 3'd0);
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = SET_ROW;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      SET_ROW: begin
        if (wrx_q) begin
          issue     = 1'b1;
          issue_dat = row_byte;
          issue_dcx = (idx_q != 3'd0);
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            pcnt_d  = '0;
            state_d = MEM_WR;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      MEM_WR: begin
        if (wrx_q) begin
          issue     = 1'b1;
          issue_dat = addr_mem_wr_i;
          issue_dcx = 1'b0;
          pcnt_d    = '0;
          state_d   = PIXEL;
        end
      end
      PIXEL: begin
        if (pcnt_q == PIX_LAST) begin
          if (wrx_q) begin
            fdone_d = 1'b1;
            idx_d   = '0;
            if (dbi_tx_start_i) begin
              state_d = SET_COL;
            end else begin
              state_d = IDLE;
              csx_d   = 1'b1;
            end
          end
        end else begin
          pxl_ready_o = wrx_q;
          if (wrx_q && pxl_valid_i) begin
            issue     = 1'b1;
            issue_dat = pxl_data_i;
            issue_dcx = 1'b1;
            pcnt_d    = pcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      d_d   = issue_dat;
      dcx_d = issue_dcx;
      wrx_d = 1'b0;
      csx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_done_q <= 1'b0;
      idx_q       <= '0;
      pcnt_q      <= '0;
      csx_q       <= 1'b1;
      dcx_q       <= 1'b1;
      wrx_q       <= 1'b1;
      d_q         <= '0;
      fdone_q     <= 1'b0;
`ifdef DBI_TX_SOFT_RST_EN
      wcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
      pcnt_q      <= pcnt_d;
      csx_q       <= csx_d;
      dcx_q       <= dcx_d;
      wrx_q       <= wrx_d;
      d_q         <= d_d;
      fdone_q     <= fdone_d;
`ifdef DBI_TX_SOFT_RST_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  assign dbi_csx_o    = csx_q;
  assign dbi_dcx_o    = dcx_q;
  assign dbi_wrx_o    = wrx_q;
  assign dbi_rdx_o    = 1'b1;
  assign dbi_d_o      = d_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = fdone_q;

endmodule
